// File: rtl/if_pkg.sv
// if_pkg: shared IF-stage constants, FSM encoding and the little-endian byte swap.
package if_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/if_perf_counters.sv
// if_perf_counters: saturating fetch/flush/stall event counters for the IF stage.
module if_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch,
    input  logic        flush,
    input  logic        stall,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_stall_cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch && !(&perf_fetch_cnt)) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (flush && !(&perf_flush_cnt)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (stall && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage owning the PC, I-cache request and IF/ID register.
// Define IF_PERF_CNT_EN to add saturating fetch/flush/stall counters.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR,
    parameter int          ADDR_W    = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memory_stall,
    input  logic              PC_write,
    input  logic              PC_src,
    input  logic              IF_flush,
    input  logic [31:0]       branch_address,
    input  logic [31:0]       IF_DWrite,
    input  logic              ICACHE_stall,
    input  logic [31:0]       ICACHE_rdata,
    output logic              ICACHE_ren,
    output logic              ICACHE_wen,
    output logic [ADDR_W-1:0] ICACHE_addr,
    output logic [31:0]       ICACHE_wdata,
    output logic [31:0]       instruction_1,
    output logic [31:0]       PC_1,
    output logic              fetch_error
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    import if_pkg::*;

    state_t      state, state_n;
    logic [31:0] pc_r, pc_n, instr_n, pc1_n;
    logic        err_n, hold, bad_target;

    // rdata is meaningless while the cache is busy, so a cache stall freezes too
    assign hold         = memory_stall | ICACHE_stall;
    assign bad_target   = PC_src && (branch_address[1:0] != 2'b00);
    assign ICACHE_ren   = (state == RUN);
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = '0;
    assign ICACHE_addr  = pc_r[ADDR_W+1:2];

    always_comb begin
        state_n = state;
        pc_n    = pc_r;
        instr_n = instruction_1;
        pc1_n   = PC_1;
        err_n   = fetch_error;
        case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (hold) begin
                    state_n = RUN;
                end else if (PC_write) begin
                    instr_n = IF_DWrite;
                end else if (bad_target) begin
                    state_n = TRAP;
                    err_n   = 1'b1;
                    instr_n = NOP_INSTR;
                end else if (PC_src || IF_flush) begin
                    pc_n    = PC_src ? branch_address : pc_r + 32'd4;
                    instr_n = NOP_INSTR;
                    pc1_n   = pc_r;
                end else begin
                    pc_n    = pc_r + 32'd4;
                    instr_n = byte_swap(ICACHE_rdata);
                    pc1_n   = pc_r;
                end
            end
            default: begin
                instr_n = NOP_INSTR;
                err_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc_r          <= RESET_PC;
            instruction_1 <= NOP_INSTR;
            PC_1          <= '0;
            fetch_error   <= 1'b0;
        end else begin
            state         <= state_n;
            pc_r          <= pc_n;
            instruction_1 <= instr_n;
            PC_1          <= pc1_n;
            fetch_error   <= err_n;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic run_free;
    assign run_free = (state == RUN) && !hold && !PC_write;

    if_perf_counters u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch          (run_free && !PC_src && !IF_flush),
        .flush          (run_free && (PC_src || IF_flush) && !bad_target),
        .stall          ((state == RUN) && hold),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench; driver pushes model expectations, monitor pops and compares.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc1;
        logic [29:0] addr;
        logic        ren;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memory_stall, dstall = 1'b0;
    logic        PC_write = 1'b0, PC_src = 1'b0, IF_flush = 1'b0, ICACHE_stall = 1'b0;
    logic [31:0] branch_address = '0, IF_DWrite = '0, ICACHE_rdata;
    logic        ICACHE_ren, ICACHE_wen, fetch_error;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_wdata, instruction_1, PC_1;

    int   tests = 0, fails = 0, cyc_n = 0;
    exp_t q[$];

    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pc1;
    logic        m_err;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .memory_stall   (memory_stall),
        .PC_write       (PC_write),
        .PC_src         (PC_src),
        .IF_flush       (IF_flush),
        .branch_address (branch_address),
        .IF_DWrite      (IF_DWrite),
        .ICACHE_stall   (ICACHE_stall),
        .ICACHE_rdata   (ICACHE_rdata),
        .ICACHE_ren     (ICACHE_ren),
        .ICACHE_wen     (ICACHE_wen),
        .ICACHE_addr    (ICACHE_addr),
        .ICACHE_wdata   (ICACHE_wdata),
        .instruction_1  (instruction_1),
        .PC_1           (PC_1),
        .fetch_error    (fetch_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [29:0] a);
        return (a < 30'd3) ? 32'h1300_0000 : {a[15:0] ^ 16'h5A3C, a[29:14] + 16'h1357};
    endfunction

    assign ICACHE_rdata = ICACHE_stall ? 32'hDEAD_BEEF : mem(ICACHE_addr);
    assign memory_stall = ICACHE_stall | dstall;

    task automatic cyc(input logic r, is, ds, pw, ps, fl, input logic [31:0] ba, dw);
        logic [31:0] w;
        exp_t e;
        @(negedge clk);
        rst_n = r; ICACHE_stall = is; dstall = ds; PC_write = pw;
        PC_src = ps; IF_flush = fl; branch_address = ba; IF_DWrite = dw;
        if (!r) begin
            m_mode = 0; m_pc = 32'h0; m_instr = NOP; m_pc1 = 32'h0; m_err = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            m_instr = NOP;
        end else if (is || ds) begin
            m_mode = 1;
        end else if (pw) begin
            m_instr = dw;
        end else if (ps && (ba % 4 != 0)) begin
            m_mode = 2; m_err = 1'b1; m_instr = NOP;
        end else if (ps || fl) begin
            m_pc1 = m_pc; m_pc = ps ? ba : m_pc + 4; m_instr = NOP;
        end else begin
            w = mem(m_pc[31:2]);
            m_instr = {<<8{w}};
            m_pc1 = m_pc; m_pc = m_pc + 4;
        end
        e.instr = m_instr; e.pc1 = m_pc1; e.addr = m_pc[31:2];
        e.ren = (m_mode == 1); e.err = m_err;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("instruction_1", instruction_1, e.instr);
                chk("PC_1", PC_1, e.pc1);
                chk("ICACHE_addr", {2'b00, ICACHE_addr}, {2'b00, e.addr});
                chk("ICACHE_ren", {31'd0, ICACHE_ren}, {31'd0, e.ren});
                chk("fetch_error", {31'd0, fetch_error}, {31'd0, e.err});
                chk("tied_write", {31'd0, ICACHE_wen} | ICACHE_wdata, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ps;
        logic [31:0] ba;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 32'h00A2_8263);
        cyc(1, 0, 0, 1, 1, 1, 32'h80, 32'h00A2_8263);
        cyc(1, 0, 0, 0, 1, 1, 32'h40, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 1, 0, 32'h100, 32'h1234_5678);
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 32'h42, 0);
        cyc(1, 0, 0, 1, 1, 1, 32'h80, 32'hFFFF_0000);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            ps = ($urandom % 7) == 0;
            ba = $urandom & 32'hFFFF_FFFC;
            if (($urandom % 16) == 0) ba[1:0] = 2'($urandom % 4);
            cyc(($urandom % 48) != 0, ($urandom % 5) == 0, ($urandom % 10) == 0,
                ($urandom % 8) == 0, ps, ($urandom % 9) == 0, ba, $urandom);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
